sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 146 ++++++++++++++
 tb/tb_sram_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store port onto a 16-bit asynchronous SRAM.
// An access runs LOW (halfword 0), HIGH (halfword 1), WAIT_CYCLES idle
// states and a single DONE cycle that releases the pipeline.
// Optional macro SRAM_ADDR_CHECK_EN: requests outside the 512 KiB window
// starting at BASE_ADDR keep the strobes idle and reads return 0, while
// still taking the full state sequence.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] sram_dq,
   output logic [17:0] sram_addr,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_ce_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned IDX_W = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t           state_q;
   logic             wr_q;
   logic             ok_q;
   logic [IDX_W-1:0] idx_q;
   logic [15:0]      wdata_hi_q;
   logic [15:0]      dq_out_q;
   logic             dq_oe_q;
   logic             we_n_q;
   logic             oe_n_q;
   logic [17:0]      sram_addr_q;
   logic [31:0]      read_data_q;
   logic [CNT_W-1:0] wait_cnt_q;

   logic             req_c;
   logic             in_range_c;
   logic [IDX_W-1:0] idx_c;

   assign req_c = rd_en | wr_en;
   // Word index relative to BASE_ADDR; out-of-window addresses wrap here.
   assign idx_c = IDX_W'((address - BASE_ADDR) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
   localparam logic [32:0] WIN_LO = 33'(BASE_ADDR);
   localparam logic [32:0] WIN_HI = 33'(BASE_ADDR) + 33'(524288);
   assign in_range_c = ({1'b0, address} >= WIN_LO) && ({1'b0, address} < WIN_HI);
`else
   assign in_range_c = 1'b1;
`endif

   // Pipeline release: combinational so a new request stalls in its own cycle.
   assign ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req_c);

   assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;
   assign sram_addr = sram_addr_q;
   assign sram_we_n = we_n_q;
   assign sram_oe_n = oe_n_q;
   assign read_data = read_data_q;
   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;

   // Access sequencer: latches the request, drives the strobes one state ahead.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         ok_q        <= 1'b0;
         idx_q       <= '0;
         wdata_hi_q  <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         sram_addr_q <= '0;
         read_data_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_c) begin
                  state_q     <= ST_LOW;
                  wr_q        <= wr_en;
                  ok_q        <= in_range_c;
                  idx_q       <= idx_c;
                  wdata_hi_q  <= write_data[31:16];
                  dq_out_q    <= write_data[15:0];
                  dq_oe_q     <= wr_en & in_range_c;
                  we_n_q      <= ~(wr_en & in_range_c);
                  oe_n_q      <= wr_en | ~in_range_c;
                  sram_addr_q <= {idx_c, 1'b0};
               end
            end
            ST_LOW: begin
               if (!wr_q) begin
                  read_data_q[15:0] <= ok_q ? sram_dq : 16'h0000;
               end
               dq_out_q    <= wdata_hi_q;
               sram_addr_q <= {idx_q, 1'b1};
               state_q     <= ST_HIGH;
            end
            ST_HIGH: begin
               if (!wr_q) begin
                  read_data_q[31:16] <= ok_q ? sram_dq : 16'h0000;
               end
               dq_oe_q    <= 1'b0;
               we_n_q     <= 1'b1;
               oe_n_q     <= 1'b1;
               wait_cnt_q <= CNT_W'(WAIT_CYCLES - 1);
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt_q == '0) begin
                  state_q <= ST_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and randomized accesses against a word-level
// reference memory; a second instance covers WAIT_CYCLES=4.
module tb_sram_controller;

   localparam int unsigned BASE  = 1024;
   localparam int unsigned W0    = 2;
   localparam int unsigned W4    = 4;
   localparam int unsigned NHW   = 262144;
   localparam logic [15:0] KEEP  = 16'hA5C3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rst4 = 1'b0;
   logic        mem_init = 1'b1;

   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] address = '0, write_data = '0, read_data;
   logic        ready, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;

   logic        wr_en4 = 1'b0, rd_en4 = 1'b0;
   logic [31:0] address4 = '0, write_data4 = '0, read_data4;
   logic        ready4, we_n4, oe_n4, ce_n4, ub_n4, lb_n4;
   logic [17:0] addr4;
   wire  [15:0] dq4;

   logic [15:0] sram  [0:NHW-1];
   logic [15:0] sram4 [0:NHW-1];

   logic [31:0] ref_mem [int unsigned];
   logic [31:0] rd_exp = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W0), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
      .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
      .sram_lb_n(sram_lb_n));

   sram_controller #(.WAIT_CYCLES(W4), .BASE_ADDR(BASE)) dut4 (
      .clk(clk), .rst(rst4), .wr_en(wr_en4), .rd_en(rd_en4), .address(address4),
      .write_data(write_data4), .read_data(read_data4), .ready(ready4),
      .sram_dq(dq4), .sram_addr(addr4), .sram_we_n(we_n4),
      .sram_oe_n(oe_n4), .sram_ce_n(ce_n4), .sram_ub_n(ub_n4),
      .sram_lb_n(lb_n4));

   // Initial SRAM contents: a fixed pattern per halfword address.
   function automatic logic [15:0] pat(input int unsigned i);
      return 16'((i * 32'd40503) ^ 32'h00005A5A);
   endfunction

   // SRAM behaviour: async read while oe_n low, write captured on the clock edge.
   assign sram_dq = (!sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'hzzzz;
   assign sram_dq = (sram_oe_n && sram_we_n) ? KEEP : 16'hzzzz;
   assign dq4     = (!oe_n4 && we_n4) ? sram4[addr4] : 16'hzzzz;
   assign dq4     = (oe_n4 && we_n4) ? KEEP : 16'hzzzz;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < NHW; i++) sram[i] <= pat(i);
      end else if (!sram_we_n && !sram_ce_n) begin
         sram[sram_addr] <= sram_dq;
      end
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < NHW; i++) sram4[i] <= pat(i);
      end else if (!we_n4 && !ce_n4) begin
         sram4[addr4] <= dq4;
      end
   end

   // Reference model: 32-bit words addressed by byte address.
   function automatic int unsigned widx(input logic [31:0] a);
      return ((a - BASE) / 4) % 131072;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
`ifdef SRAM_ADDR_CHECK_EN
      return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'd524288);
`else
      return (a == a);
`endif
   endfunction

   function automatic logic [31:0] ref_word(input int unsigned w);
      if (ref_mem.exists(w)) return ref_mem[w];
      return {pat(2 * w + 1), pat(2 * w)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access on the default instance, checked cycle by cycle.
   task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit scramble);
      bit          is_wr = wr;
      bit          ok    = in_range(a);
      int unsigned w     = widx(a);
      int unsigned lat   = 3 + W0;
      logic [31:0] exp_rd;
      @(negedge clk);
      rd_en = rd; wr_en = wr; address = a; write_data = d;
      #1 chk("req_ready", 32'(ready), 32'd0);
      if (!is_wr) exp_rd = ok ? ref_word(w) : 32'd0;
      else begin
         exp_rd = rd_exp;
         if (ok) ref_mem[w] = d;
      end
      for (int c = 1; c <= int'(lat); c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == int'(lat)));
         chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(!(is_wr && ok && c <= 2)));
         chk($sformatf("oe_n_c%0d", c), 32'(sram_oe_n), 32'(!(!is_wr && ok && c <= 2)));
         if (c <= 2) begin
            chk($sformatf("addr_c%0d", c), 32'(sram_addr), 2 * w + ((c == 2) ? 1 : 0));
            if (is_wr && ok)
               chk($sformatf("dq_wr_c%0d", c), 32'(sram_dq), (c == 1) ? 32'(d[15:0]) : 32'(d[31:16]));
            else if (!ok)
               chk($sformatf("dq_idle_c%0d", c), 32'(sram_dq), 32'(KEEP));
         end else begin
            chk($sformatf("dq_z_c%0d", c), 32'(sram_dq), 32'(KEEP));
         end
         if (scramble && c < int'(lat)) begin
            rd_en = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
            address = $urandom; write_data = $urandom;
         end else begin
            rd_en = 1'b0; wr_en = 1'b0;
         end
      end
      rd_exp = exp_rd;
      chk("read_data", read_data, rd_exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] old;
      // Reset state
      @(negedge clk);
      mem_init = 1'b0;
      #1;
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq", 32'(sram_dq), 32'(KEEP));
      chk("rst_ready", 32'(ready), 32'd1);
      chk("tied_strobes", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
      @(negedge clk);
      rst = 1'b1; rst4 = 1'b1;
      #1 chk("idle_ready", 32'(ready), 32'd1);

      // Write then read back at the base address
      txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
      chk("sram_hw0", 32'(sram[0]), 32'h0000BEEF);
      chk("sram_hw1", 32'(sram[1]), 32'h0000DEAD);
      txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      chk("rd_deadbeef", read_data, 32'hDEADBEEF);

      // Read and write together perform a write
      txn(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0);
      chk("both_keeps_rd", read_data, 32'hDEADBEEF);
      txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
      chk("rd_12345678", read_data, 32'h12345678);

      // Reset during HIGH of a write aborts the upper halfword
      txn(1'b0, 1'b1, 32'd1040, 32'hAAAA5555, 1'b0);
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h12345678;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      #1 chk("abort_we_low", 32'(sram_we_n), 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
      chk("abort_dq", 32'(sram_dq), 32'(KEEP));
      chk("abort_addr", 32'(sram_addr), 32'd0);
      chk("abort_rd", read_data, 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      old = ref_word(widx(32'd1040));
      ref_mem[widx(32'd1040)] = {old[31:16], 16'h5678};
      rd_exp = 32'd0;
      txn(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
      chk("abort_old_hi", read_data, 32'hAAAA5678);

      // Outside the window: dropped when checked, wrapped otherwise
      txn(1'b0, 1'b1, 32'd512, 32'hCAFEF00D, 1'b0);
      txn(1'b1, 1'b0, 32'd512, 32'h0, 1'b0);
      txn(1'b1, 1'b0, 32'd1024 + 32'd524288, 32'h0, 1'b0);

      // Randomized traffic with input churn after latching
      for (int n = 0; n < 50; n++) begin
         int unsigned k = $urandom_range(0, 2);
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = BASE + 4 * $urandom_range(0, 31);
         txn(k != 1, k != 0, a, $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            #1 chk("gap_ready", 32'(ready), 32'd1);
         end
      end

      // Longer wait: read at 1028 on the WAIT_CYCLES=4 instance
      @(negedge clk);
      rd_en4 = 1'b1; address4 = 32'd1028;
      #1 chk("w4_ready_c0", 32'(ready4), 32'd0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("w4_ready_c%0d", c), 32'(ready4), 32'(c == 7));
         if (c == 1) chk("w4_addr_c1", 32'(addr4), 32'd2);
         if (c == 2) chk("w4_addr_c2", 32'(addr4), 32'd3);
         rd_en4 = 1'b0;
      end
      chk("w4_read_data", read_data4, {pat(3), pat(2)});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
